// File: rtl/irq_pkg.sv
// Shared constants, state encoding and helpers for the interrupt controller.
package irq_pkg;

    // Word offsets inside the 4-word register window (address[3:2]).
    localparam logic [1:0] PEND_OFF  = 2'd0;
    localparam logic [1:0] MASK_OFF  = 2'd1;
    localparam logic [1:0] CLAIM_OFF = 2'd2;
    localparam logic [1:0] EOI_OFF   = 2'd3;

    // Bit of the CLAIM read word that flags "an eligible request exists".
    localparam int CLAIM_VALID_BIT = 31;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ASSERT     = 2'd1,
        IN_SERVICE = 2'd2
    } irq_state_t;

    // One-hot decode of a source index; callers slice the low NUM_SRC bits.
    function automatic logic [15:0] onehot16(input logic [4:0] idx);
        logic [15:0] v;
        v = 16'h0000;
        v[idx[3:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins, reports whether any bit is set.
module irq_prio_enc #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] vec,
    output logic               any,
    output logic [4:0]         index
);

    // Scan from the top down so the last hit (lowest index) is the one kept.
    always_comb begin
        any   = |vec;
        index = 5'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            index = vec[i] ? 5'(i) : index;
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge-latched pending bits, software mask,
// one prioritized request to cp0 with claim-by-load / EOI-by-store handshake.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_SRC   = 4,
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0010
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [31:0]        address,
    input  logic [31:0]        data_in,
    input  logic               MemRead,
    input  logic               MemWrite,
    output logic [31:0]        data_out,
    output logic               IrqAddress,
    output logic               irq_out
);

    localparam logic [NUM_SRC-1:0] ZERO_SRC = {NUM_SRC{1'b0}};

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] prev_src;
    logic [NUM_SRC-1:0] edges;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] claim_bit;
    logic [15:0]        best_onehot;
    logic [4:0]         best;
    logic [4:0]         in_service_id;
    logic               any;
    logic [1:0]         offset;
    logic               rd_hit;
    logic               wr_hit;
    logic               claim_fire;
    logic               eoi_fire;
    irq_state_t         state;

    // Bus decode: the window is 16 bytes, so only address[31:4] selects it.
    assign IrqAddress = (address[31:4] == BASE_ADDR[31:4]);
    assign offset     = address[3:2];
    assign rd_hit     = IrqAddress & MemRead;
    assign wr_hit     = IrqAddress & MemWrite;

    assign edges    = irq_src & ~prev_src;
    assign eligible = pending & mask;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_best (
        .vec   (eligible),
        .any   (any),
        .index (best)
    );

    // A claim only takes effect while a request is actually being presented.
    assign claim_fire = (state == ASSERT) && rd_hit && (offset == CLAIM_OFF) && any;
    assign eoi_fire   = (state == IN_SERVICE) && wr_hit && (offset == EOI_OFF);

    assign best_onehot = onehot16(best);
    assign claim_bit   = claim_fire ? best_onehot[NUM_SRC-1:0] : ZERO_SRC;
    assign w1c         = (wr_hit && (offset == PEND_OFF)) ? data_in[NUM_SRC-1:0] : ZERO_SRC;
    assign clr         = w1c | claim_bit;

    // Source history, pending and mask registers; a new edge beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_src <= ZERO_SRC;
            pending  <= ZERO_SRC;
            mask     <= ZERO_SRC;
        end else begin
            prev_src <= irq_src;
            pending  <= (pending & ~clr) | edges;
            if (wr_hit && (offset == MASK_OFF)) begin
                mask <= data_in[NUM_SRC-1:0];
            end else begin
                mask <= mask;
            end
        end
    end

    // Request FSM; irq_out is registered alongside the state it decodes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            irq_out       <= 1'b0;
            in_service_id <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        state   <= ASSERT;
                        irq_out <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        irq_out <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (claim_fire) begin
                        state         <= IN_SERVICE;
                        irq_out       <= 1'b0;
                        in_service_id <= best;
                    end else if (!any) begin
                        state   <= IDLE;
                        irq_out <= 1'b0;
                    end else begin
                        state   <= ASSERT;
                        irq_out <= 1'b1;
                    end
                end
                IN_SERVICE: begin
                    irq_out <= 1'b0;
                    if (eoi_fire) begin
                        state <= IDLE;
                    end else begin
                        state <= IN_SERVICE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    irq_out <= 1'b0;
                end
            endcase
        end
    end

    // Read mux; drives zero whenever this block is not the load target.
    always_comb begin
        data_out = 32'h0000_0000;
        if (rd_hit) begin
            case (offset)
                PEND_OFF:  data_out = 32'(pending);
                MASK_OFF:  data_out = 32'(mask);
                CLAIM_OFF: begin
                    data_out                  = {27'h0000000, best};
                    data_out[CLAIM_VALID_BIT] = any;
                end
                EOI_OFF:   data_out = 32'h0000_0000;
                default:   data_out = 32'h0000_0000;
            endcase
        end else begin
            data_out = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: stimulus queues expectations, a
// negedge monitor pops and compares them against what the DUT presents.
module tb_irq_controller;

    localparam logic [31:0] BASE = 32'hFFFF0010;
    localparam logic [1:0]  PEND = 2'd0;
    localparam logic [1:0]  MSK  = 2'd1;
    localparam logic [1:0]  CLM  = 2'd2;
    localparam logic [1:0]  EOI  = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  irq_src = 4'h0;
    logic [31:0] address = 32'h0;
    logic [31:0] data_in = 32'h0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] data_out;
    logic        IrqAddress;
    logic        irq_out;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t rd_q[$];
    exp_t irq_q[$];
    exp_t addr_q[$];
    int   checks = 0;
    int   failures = 0;

    irq_controller #(
        .NUM_SRC   (4),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .address    (address),
        .data_in    (data_in),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .data_out   (data_out),
        .IrqAddress (IrqAddress),
        .irq_out    (irq_out)
    );

    always #5 clk = ~clk;

    // Monitor: compare every queued expectation at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        while (irq_q.size() > 0) begin
            e = irq_q.pop_front();
            checks++;
            if (irq_out !== e.val[0]) begin
                failures++;
                $display("FAIL %s irq_out actual=%b required=%b", e.name, irq_out, e.val[0]);
            end
        end
        while (addr_q.size() > 0) begin
            e = addr_q.pop_front();
            checks++;
            if (IrqAddress !== e.val[0]) begin
                failures++;
                $display("FAIL %s IrqAddress actual=%b required=%b", e.name, IrqAddress, e.val[0]);
            end
        end
        if (MemRead && IrqAddress) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read data_out actual=%h required=none", data_out);
            end else begin
                e = rd_q.pop_front();
                if (data_out !== e.val) begin
                    failures++;
                    $display("FAIL %s data_out actual=%h required=%h", e.name, data_out, e.val);
                end
            end
        end
    end

    task automatic bus(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data);
        @(posedge clk);
        #1;
        MemRead  = rd;
        MemWrite = wr;
        address  = addr;
        data_in  = data;
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000);
    endtask

    task automatic wr_reg(input logic [1:0] off, input logic [31:0] data);
        bus(1'b0, 1'b1, BASE + {28'h0000000, off, 2'b00}, data);
    endtask

    task automatic rd_exp(input string name, input logic [1:0] off, input logic [31:0] val);
        exp_t e;
        bus(1'b1, 1'b0, BASE + {28'h0000000, off, 2'b00}, 32'h0000_0000);
        e.name = name;
        e.val  = val;
        rd_q.push_back(e);
    endtask

    task automatic irq_exp(input string name, input logic val);
        exp_t e;
        e.name = name;
        e.val  = {31'h0, val};
        irq_q.push_back(e);
    endtask

    task automatic addr_exp(input string name, input logic val);
        exp_t e;
        e.name = name;
        e.val  = {31'h0, val};
        addr_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two cycles with quiet sources.
        idle();
        idle();
        reset = 1'b0;
        irq_exp("rst_irq", 1'b0);
        rd_exp("rst_pend", PEND, 32'h0); irq_exp("rst_irq2", 1'b0);
        rd_exp("rst_mask", MSK, 32'h0);
        rd_exp("rst_claim", CLM, 32'h0);

        // Single request on source 1.
        wr_reg(MSK, 32'h2);
        idle(); irq_src = 4'b0010; irq_exp("single_pre", 1'b0);
        idle(); irq_src = 4'b0000; irq_exp("single_pend_cyc", 1'b0);
        idle(); irq_exp("single_assert", 1'b1);
        rd_exp("single_claim", CLM, 32'h8000_0001); irq_exp("single_hold", 1'b1);
        rd_exp("single_pend_clr", PEND, 32'h0); irq_exp("single_insvc", 1'b0);
        wr_reg(EOI, 32'h0); irq_exp("single_eoi", 1'b0);
        idle(); irq_exp("single_idle1", 1'b0);
        idle(); irq_exp("single_idle2", 1'b0);

        // Priority: sources 3 and 0 together, then 1 during service.
        wr_reg(MSK, 32'hF);
        idle(); irq_src = 4'b1001;
        idle(); irq_src = 4'b0000; irq_exp("prio_pend_cyc", 1'b0);
        rd_exp("prio_claim0", CLM, 32'h8000_0000); irq_exp("prio_assert", 1'b1);
        idle(); irq_src = 4'b0010; irq_exp("prio_insvc", 1'b0);
        idle(); irq_src = 4'b0000; irq_exp("prio_new_edge", 1'b0);
        rd_exp("prio_pend", PEND, 32'h0000_000A); irq_exp("prio_insvc2", 1'b0);
        rd_exp("prio_claim_insvc", CLM, 32'h8000_0001); irq_exp("prio_insvc3", 1'b0);
        idle(); irq_exp("prio_no_state_change", 1'b0);
        wr_reg(EOI, 32'h0); irq_exp("prio_eoi", 1'b0);
        idle(); irq_exp("prio_idle", 1'b0);
        rd_exp("prio_claim1", CLM, 32'h8000_0001); irq_exp("prio_reassert", 1'b1);
        wr_reg(EOI, 32'h0); irq_exp("prio_insvc4", 1'b0);
        idle(); irq_exp("prio_idle2", 1'b0);
        rd_exp("prio_claim3", CLM, 32'h8000_0003); irq_exp("prio_reassert2", 1'b1);
        wr_reg(EOI, 32'h0); irq_exp("prio_insvc5", 1'b0);
        idle(); irq_exp("prio_idle3", 1'b0);
        rd_exp("prio_pend_empty", PEND, 32'h0); irq_exp("prio_quiet", 1'b0);

        // Masking and write-1-to-clear.
        wr_reg(MSK, 32'h0);
        idle(); irq_src = 4'b0100;
        idle(); irq_src = 4'b0000; irq_exp("mask_pend_cyc", 1'b0);
        rd_exp("mask_pend", PEND, 32'h0000_0004); irq_exp("mask_blocked", 1'b0);
        wr_reg(MSK, 32'h4); irq_exp("mask_wr", 1'b0);
        idle(); irq_exp("mask_idle_eval", 1'b0);
        idle(); irq_exp("mask_assert", 1'b1);
        wr_reg(PEND, 32'h4); irq_exp("w1c_store", 1'b1);
        rd_exp("w1c_pend", PEND, 32'h0); irq_exp("w1c_lag", 1'b1);
        idle(); irq_exp("w1c_drop", 1'b0);

        // Edge on source 0 coinciding with a W1C of bit 0.
        idle(); irq_src = 4'b0001;
        idle(); irq_src = 4'b0000;
        wr_reg(PEND, 32'h1); irq_src = 4'b0001;
        rd_exp("collide_pend", PEND, 32'h0000_0001); irq_src = 4'b0000;
        wr_reg(PEND, 32'h1);
        rd_exp("collide_cleared", PEND, 32'h0);

        // Bus decode: in-window EOI read, out-of-window stores.
        rd_exp("dec_eoi_read", EOI, 32'h0); addr_exp("dec_1c", 1'b1);
        bus(1'b0, 1'b1, 32'hFFFF_0020, 32'hF); addr_exp("dec_20", 1'b0);
        bus(1'b0, 1'b1, 32'h1001_0000, 32'hF); addr_exp("dec_data", 1'b0);
        bus(1'b0, 1'b1, 32'hFFFF_0024, 32'h0); addr_exp("dec_24", 1'b0);
        rd_exp("dec_mask_kept", MSK, 32'h0000_0004); addr_exp("dec_10", 1'b1);
        rd_exp("dec_pend_kept", PEND, 32'h0);

        // Reset while in service.
        idle(); irq_src = 4'b0100;
        idle(); irq_src = 4'b0000;
        idle(); irq_exp("rs_assert", 1'b1);
        rd_exp("rs_claim", CLM, 32'h8000_0002);
        idle(); irq_src = 4'b1000; irq_exp("rs_insvc", 1'b0);
        idle(); irq_src = 4'b0000; reset = 1'b1;
        idle(); reset = 1'b0; irq_exp("rs_after", 1'b0);
        rd_exp("rs_pend", PEND, 32'h0);
        rd_exp("rs_mask", MSK, 32'h0);
        rd_exp("rs_claim_zero", CLM, 32'h0);
        wr_reg(MSK, 32'h1);
        idle(); irq_src = 4'b0001;
        idle(); irq_src = 4'b0000; irq_exp("rs_fsm_pend", 1'b0);
        idle(); irq_exp("rs_fsm_idle_ok", 1'b1);

        // Drain: every queued expectation must have been consumed.
        idle();
        idle();
        idle();
        checks++;
        if (rd_q.size() != 0 || irq_q.size() != 0 || addr_q.size() != 0) begin
            failures++;
            $display("FAIL drain leftover actual=%0d required=0",
                     rd_q.size() + irq_q.size() + addr_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller that sits between the peripheral interrupt sources (timer plus external lines) and cp0's single interrupt input.
- Latches rising edges into a pending register, applies a software mask, and presents one prioritized request to cp0.
- Handlers claim the request by a load and finish it by an EOI store.
- Shares the lw/sw data path with data_mem. Its address-hit output gates data_mem enables, the same way the timer does.

Parameters:
- NUM_SRC, 4, number of interrupt source lines (1..16); index 0 is highest priority.
- BASE_ADDR, 32'hFFFF0010, word-aligned base of the 4-word register window.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- irq_src  in  NUM_SRC  raw source lines, level; rising edge = request
- address  in  32  ALU result (load/store effective address)
- data_in  in  32  store data (rd2)
- MemRead  in  1  load in current instruction
- MemWrite  in  1  store in current instruction
- data_out  out  32  read data, combinational, valid when IrqAddress & MemRead
- IrqAddress  out  1  combinational, 1 when address[31:4]==BASE_ADDR[31:4]
- irq_out  out  1  registered request to cp0 (TimerInterrupt-style input)

Behaviour:
- Register map, word offsets (address[3:2]); address[1:0] ignored:
  - 0 PENDING: read = pending; write = write-1-to-clear.
  - 1 MASK: read/write; 1 = enabled.
  - 2 CLAIM: read only; writes ignored.
  - 3 EOI: write only, data ignored; reads return 0.
- Bits above NUM_SRC-1 read 0.
- Access occurs only when IrqAddress & MemRead or IrqAddress & MemWrite.
- Reset, all values zero: pending, mask, in_service_id, prev_src, state=IDLE, irq_out=0.
- prev_src resets to 0. A line already high at reset release therefore latches pending on the first clock.
- Edge detect: edge = irq_src & ~prev_src; prev_src <= irq_src every cycle.
- Pending update: pending <= (pending & ~clr) | edge.
  - clr = W1C data, or the one-hot claimed bit.
  - A set always wins over a same-cycle clear of the same bit.
- Eligibility: eligible = pending & mask. best = lowest set index of eligible.
- CLAIM read data: {eligible!=0, 26'b0, best[4:0]}, combinational.
- States:
  - IDLE: eligible!=0 -> ASSERT.
  - ASSERT: irq_out=1.
    - CLAIM read with eligible!=0 -> IN_SERVICE. Clears pending[best]; in_service_id<=best.
    - eligible==0 (masked or W1C-cleared) -> IDLE.
  - IN_SERVICE: irq_out=0. New requests stay pending. EOI write -> IDLE.
- Timing: if more are eligible at EOI, irq_out reasserts 2 cycles after the EOI store (IDLE then ASSERT).
- CLAIM read in IDLE or IN_SERVICE: returns the current value, no state change. Claim read with eligible==0 returns 0 and has no effect.
- EOI write in IDLE or ASSERT is ignored.
- Simultaneous edge and claim on the same bit: pending stays 1 and the source is serviced again later.
- irq_out is the registered state decode (state==ASSERT): no combinational path from inputs.
- Mid-operation reset: every state returns to reset values on that edge; any in-service context is lost.
- Sizes: NUM_SRC bits for source vectors; in_service_id is 5 bits.

Decomposition:
- Shared package irq_pkg:
  - register offset constants PEND_OFF=0, MASK_OFF=1, CLAIM_OFF=2, EOI_OFF=3;
  - state encoding IDLE/ASSERT/IN_SERVICE (2-bit);
  - CLAIM valid-bit position (31).
- One sub-module, irq_prio_enc: parameterized NUM_SRC vector -> {any, index[4:0]}, lowest index wins; purely combinational, reused for best.
- Register flops use the existing register module where width allows.

Test Plan:
- Reset behaviour: reset held 2 cycles with irq_src=0 -> irq_out=0, PENDING/MASK/CLAIM reads = 0.
- Single request: MASK<=4'b0010; pulse irq_src[1] -> irq_out=1 two cycles after the edge (pending, then ASSERT). CLAIM read returns 32'h80000001; next cycle irq_out=0 and PENDING=0. EOI store -> IDLE, irq_out stays 0.
- Priority: MASK=4'hF; edges on src 3 and 0 same cycle.
  - CLAIM returns 0.
  - Edge on src 1 during IN_SERVICE keeps irq_out=0.
  - After EOI, irq_out=1 two cycles later; CLAIM returns 1, then 3 on the following claim/EOI.
- Masking and W1C: MASK=0, edge on src 2 -> PENDING=4'b0100, irq_out stays 0. MASK<=4'b0100 -> irq_out=1. Store 4'b0100 to PENDING -> irq_out=0 next cycle, PENDING=0.
- Set-over-clear collision: W1C of bit 0 in the same cycle as a new rising edge on src 0 -> PENDING[0]=1 afterward.
- Bus decode: address 0xFFFF001C -> IrqAddress=1; addresses 0xFFFF0020 and 0x10010000 -> IrqAddress=0 and no register change on store. Reset asserted while IN_SERVICE -> IDLE, all registers 0.
